// File: rtl/phase_timer.sv
// Traffic-light phase countdown: finished pulses every N*prescale+2 cycles; restart yields FIN next clock.
// Everything holds while enable_general=0. Define PHASE_TIMER_FAST_SIM_EN to force a prescale of 10.
module phase_timer #(
  parameter int PRESCALE = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_general,
  input  logic        restart,
  input  logic [15:0] secondsToCount,
  output logic        finished,
  output logic [15:0] seconds_left,
  output logic        tick_1hz,
  output logic        busy
);

`ifdef PHASE_TIMER_FAST_SIM_EN
  // PRESCALE is referenced only to keep the parameter visible; the fast build always uses 10.
  localparam int EFF_PRESCALE = (PRESCALE > 0) ? 10 : 10;
`else
  localparam int EFF_PRESCALE = PRESCALE;
`endif
  localparam int PW = (EFF_PRESCALE > 1) ? $clog2(EFF_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(EFF_PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, FIN, LOAD, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic          wrap;
  logic          last_sec;

  assign wrap     = (state == RUN) && enable_general && (presc == PRESC_LAST);
  assign last_sec = (seconds_left <= 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A restart seen while already in FIN is satisfied by the pulse in flight, so
  // finished can never fire on two consecutive cycles.
  always_comb begin
    state_nxt = state;
    if (enable_general) begin
      if (restart) begin
        state_nxt = (state == FIN) ? LOAD : FIN;
      end else begin
        case (state)
          IDLE:    state_nxt = FIN;
          FIN:     state_nxt = LOAD;
          LOAD:    state_nxt = RUN;
          RUN:     state_nxt = (wrap && last_sec) ? FIN : RUN;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc        <= '0;
      seconds_left <= '0;
    end else if (enable_general) begin
      if (state == LOAD) begin
        presc        <= '0;
        seconds_left <= (secondsToCount == 16'd0) ? 16'd1 : secondsToCount;
      end else if (state == RUN) begin
        if (wrap) begin
          presc <= '0;
          if (seconds_left != 16'd0) begin
            seconds_left <= seconds_left - 16'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  always_comb begin
    finished = enable_general && (state == FIN);
    tick_1hz = wrap;
    busy     = (state == RUN);
  end

endmodule

// File: tb/tb_phase_timer.sv
// Randomised + directed bench for phase_timer; an enabled-cycle schedule model feeds a scoreboard
// that the negedge monitor drains whenever finished or tick_1hz fires.
module tb_phase_timer;
  localparam int P = 10;

  logic        clk;
  logic        reset;
  logic        enable_general;
  logic        restart;
  logic [15:0] secondsToCount;
  logic        finished;
  logic [15:0] seconds_left;
  logic        tick_1hz;
  logic        busy;

  phase_timer #(.PRESCALE(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_general (enable_general),
    .restart        (restart),
    .secondsToCount (secondsToCount),
    .finished       (finished),
    .seconds_left   (seconds_left),
    .tick_1hz       (tick_1hz),
    .busy           (busy)
  );

  typedef struct {
    bit          is_fin;
    int          cyc;
    logic [15:0] sl;
    bit          busy;
  } ev_t;

  ev_t  exp_q[$];
  int   fin_log[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   prev_fin = 0;

  // Model state, counted in enabled cycles: mf is the enabled-cycle index of the current/next FIN.
  int          mk, mf, mN;
  logic [15:0] msl;
  bit          mstarted, m_fin, m_tick;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input bit is_fin);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: DUT pulsed at cycle %0d, none expected", is_fin ? "finished" : "tick", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_fin != is_fin || e.cyc != cyc || e.sl != seconds_left || e.busy != busy) begin
        n_fail++;
        $display("FAIL event: got fin=%0b cyc=%0d sl=%0d busy=%0b, expected fin=%0b cyc=%0d sl=%0d busy=%0b",
                 is_fin, cyc, seconds_left, busy, e.is_fin, e.cyc, e.sl, e.busy);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (finished) begin
        fin_log.push_back(cyc);
        chk("no_back_to_back_finished", int'(prev_fin), 0);
        pop_check(1'b1);
      end
      if (tick_1hz) pop_check(1'b0);
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missed_event: %0d expected pulse(s) absent at cycle %0d, first due cycle %0d",
                 exp_q.size(), cyc, exp_q[0].cyc);
        exp_q.delete();
      end
    end
    prev_fin = reset && finished;
  end

  task automatic model_reset();
    mk = 0; mf = 0; mN = 1; msl = 16'd0; mstarted = 0;
    m_fin = 0; m_tick = 0;
    exp_q.delete();
  endtask

  // Phase position p: 0 = FIN, 1 = LOAD, ticks at 1+j*P, next FIN at N*P+2.
  task automatic model_cycle();
    int  p;
    ev_t e;
    m_fin = 0;
    m_tick = 0;
    if (!enable_general) return;
    p = mk - mf;
    if (mstarted) begin
      m_fin  = (p == 0);
      m_tick = (p >= 2) && (p <= 1 + mN * P) && ((p - 1) % P == 0);
    end
    if (m_fin) begin
      e.is_fin = 1'b1; e.cyc = cyc; e.sl = msl; e.busy = 1'b0;
      exp_q.push_back(e);
    end
    if (m_tick) begin
      e.is_fin = 1'b0; e.cyc = cyc; e.sl = msl; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    if (mstarted && p == 1) begin
      mN  = (secondsToCount == 16'd0) ? 1 : int'(secondsToCount);
      msl = 16'(mN);
    end
    if (m_tick && msl != 16'd0) msl = msl - 16'd1;
    if (!mstarted || (restart && p != 0) || (mstarted && p == 1 + mN * P)) begin
      mf = mk + 1;
      mstarted = 1;
    end
    mk++;
  endtask

  task automatic drive_cycle(input logic en, input logic rs, input logic [15:0] stc);
    @(posedge clk);
    #1;
    enable_general = en;
    restart        = rs;
    secondsToCount = stc;
    model_cycle();
  endtask

  task automatic run_to_fin(input logic [15:0] stc, input int limit);
    int n = 0;
    do begin
      drive_cycle(1'b1, 1'b0, stc);
      n++;
    end while (!m_fin && n < limit);
    if (!m_fin) chk("run_to_fin_bound", n, -1);
  endtask

  task automatic release_reset(output int rel);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    rel = cyc;
    model_cycle();
  endtask

  initial begin
    int rel, rc, wc, cnt;
    reset = 1'b1; enable_general = 1'b1; restart = 1'b0; secondsToCount = 16'd3;
    model_reset();
    #1 reset = 1'b0;
    #11;
    chk("reset_finished", int'(finished), 0);
    chk("reset_tick", int'(tick_1hz), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_seconds_left", int'(seconds_left), 0);

    // 3 s phase: finished at cycle 1 and 33 after release
    release_reset(rel);
    run_to_fin(16'd3, 10);
    @(negedge clk); #1;
    chk("first_fin_cycle", fin_log.size() > 0 ? fin_log[$] - rel : -1, 1);
    run_to_fin(16'd3, 40);
    @(negedge clk); #1;
    chk("fin_cycle_n3", fin_log.size() > 0 ? fin_log[$] - rel : -1, 33);

    // zero loads as one second
    run_to_fin(16'd0, 20);
    @(negedge clk); #1;
    chk("gap_n0", fin_log.size() > 1 ? fin_log[$] - fin_log[$-1] : -1, 12);

    // 7 disabled cycles mid-RUN stretch the phase by 7
    repeat (6) drive_cycle(1'b1, 1'b0, 16'd2);
    repeat (7) begin
      drive_cycle(1'b0, 1'b0, 16'd2);
      chk("hold_seconds_left", int'(seconds_left), int'(msl));
    end
    run_to_fin(16'd2, 40);
    @(negedge clk); #1;
    chk("gap_disabled", fin_log.size() > 1 ? fin_log[$] - fin_log[$-1] : -1, 29);

    // restart mid-RUN with 5 s loaded
    repeat (21) drive_cycle(1'b1, 1'b0, 16'd5);
    drive_cycle(1'b1, 1'b1, 16'd5);
    rc = cyc;
    drive_cycle(1'b1, 1'b0, 16'd5);
    @(negedge clk); #1;
    chk("restart_fin_next", fin_log.size() > 0 ? fin_log[$] - rc : -1, 1);
    drive_cycle(1'b1, 1'b0, 16'd5);
    drive_cycle(1'b1, 1'b0, 16'd5);
    chk("busy_after_load", int'(busy), 1);

    // restart on the terminal wrap of a 1 s phase
    run_to_fin(16'd5, 80);
    drive_cycle(1'b1, 1'b0, 16'd1);
    repeat (P - 1) drive_cycle(1'b1, 1'b0, 16'd1);
    drive_cycle(1'b1, 1'b1, 16'd1);
    wc = cyc;
    repeat (3) drive_cycle(1'b1, 1'b0, 16'd4);
    @(negedge clk); #1;
    cnt = 0;
    foreach (fin_log[i]) if (fin_log[i] > wc) cnt++;
    chk("restart_at_wrap_pulses", cnt, 1);
    chk("restart_at_wrap_gap", fin_log.size() > 1 ? fin_log[$] - fin_log[$-1] : -1, 12);

    // asynchronous reset mid-RUN
    repeat (15) drive_cycle(1'b1, 1'b0, 16'd4);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrun_reset_finished", int'(finished), 0);
    chk("midrun_reset_tick", int'(tick_1hz), 0);
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_seconds_left", int'(seconds_left), 0);
    @(posedge clk);
    @(posedge clk);
    release_reset(rel);
    drive_cycle(1'b1, 1'b0, 16'd2);
    @(negedge clk); #1;
    chk("fin_after_reset", fin_log.size() > 0 ? fin_log[$] - rel : -1, 1);

    // random enable gaps, restarts and durations
    for (int i = 0; i < 800; i++) begin
      drive_cycle(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  16'($urandom_range(0, 3)));
    end
    drive_cycle(1'b1, 1'b0, 16'd1);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
